sd_card_responder: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 31 +++
 rtl/spi_byte_slave.sv | 76 +++++++
 rtl/sd_card_responder.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_sd_card_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SPI-mode SD card responder.
// Holds command indices, R1 bit positions, the data token, the OCR value
// reported by CMD58, the frame-state enum and an R1 builder.
package sd_spi_pkg;

    localparam logic [5:0] CmdGoIdle     = 6'd0;
    localparam logic [5:0] CmdSendIfCond = 6'd8;
    localparam logic [5:0] CmdReadSingle = 6'd17;
    localparam logic [5:0] CmdAppOpCond  = 6'd41;
    localparam logic [5:0] CmdAppCmd     = 6'd55;
    localparam logic [5:0] CmdReadOcr    = 6'd58;

    localparam int unsigned R1IdleBit    = 0;
    localparam int unsigned R1IllegalBit = 2;

    localparam logic [7:0]  DataToken = 8'hFE;
    localparam logic [31:0] Ocr       = 32'hC0FF8000;

    typedef enum logic [2:0] {
        StHunt, StCmd, StNcr, StResp, StNac, StToken, StData, StCrc
    } frame_state_e;

    function automatic logic [7:0] r1_byte(input logic idle, input logic illegal);
        logic [7:0] r;
        r = 8'h00;
        r[R1IdleBit]    = idle;
        r[R1IllegalBit] = illegal;
        return r;
    endfunction

endpackage

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte engine clocked by the system clock.
// Ports:
//   clk, rst          system clock, async active-high reset
//   spi_clk, cs, mosi raw SPI pins (asynchronous to clk)
//   tx_byte           byte to send in the next slot, taken on byte_done
//   miso              card-to-host data, changes on synchronised spi_clk fall
//   byte_done         one-clk pulse on every 8th synchronised rise (cs low)
//   rx_byte           received byte, valid while byte_done is high
//   cs_high           synchronised chip-select deasserted
module spi_byte_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       cs,
    input  logic       mosi,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       cs_high
);

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_prev;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic       sclk_rise, sclk_fall;

    assign cs_high   = cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    // Gated by cs so a rise coinciding with deselect never completes a byte.
    assign byte_done = sclk_rise & ~cs_high & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift, mosi_sync[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_prev <= sclk_sync[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            tx_shift <= 8'hFF;
            miso     <= 1'b1;
        end else if (cs_high) begin
            bit_cnt  <= 3'd0;
            tx_shift <= 8'hFF;
            miso     <= 1'b1;
        end else begin
            if (sclk_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            // Load happens on a rise, shifting on a fall: never the same cycle.
            if (byte_done) begin
                tx_shift <= tx_byte;
            end else if (sclk_fall) begin
                miso     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/sd_card_responder.sv
// Card-side SPI-mode SD responder: decodes 48-bit command frames, tracks the
// initialisation state and answers with R1/R3/R7 plus CMD17 block reads.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   spi_clk, cs, mosi, miso  SPI link to the host
//   cmd_valid/index/arg      pulse and fields of each accepted frame
//   card_ready               ACMD41 has reported not-busy
//   blk_addr                 CMD17 argument of the current read
//   byte_req/byte_in/valid   block byte source handshake
//   underrun                 sticky: a block byte was missing at load time
module sd_card_responder #(
    parameter int unsigned ACMD41_BUSY_COUNT = 2,
    parameter int unsigned NCR_BYTES         = 1,
    parameter int unsigned NAC_BYTES         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        card_ready,
    output logic [31:0] blk_addr,
    output logic        byte_req,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        underrun
);
    import sd_spi_pkg::*;

    localparam logic [9:0] NcrLast   = 10'(NCR_BYTES - 1);
    localparam logic [9:0] NacLast   = 10'(NAC_BYTES - 1);
    localparam logic [7:0] BusyCount = 8'(ACMD41_BUSY_COUNT);

    logic         byte_done, cs_high;
    logic [7:0]   rx_byte, tx_byte;
    frame_state_e state_q, state_d;
    logic [9:0]   cnt_q, cnt_d;
    logic [5:0]   fr_idx_q, fr_idx_d;
    logic [31:0]  fr_arg_q, fr_arg_d;
    logic [39:0]  resp_q;
    logic         resp_long_q, rd_q;
    logic         idle_q, app_q;
    logic [7:0]   acnt_q;
    logic [7:0]   data_q;
    logic         have_q, pend_q;
    logic         exec, req, load_data, resp_shift;

    // Command decode results, applied when exec fires.
    logic         idle_n, app_n, ready_n, clr_ur, rd_new, resp_long_n;
    logic [7:0]   acnt_n, r1;
    logic [31:0]  payload;
    logic [39:0]  resp_new;

    spi_byte_slave u_byte (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .cs        (cs),
        .mosi      (mosi),
        .tx_byte   (tx_byte),
        .miso      (miso),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .cs_high   (cs_high)
    );

    always_comb begin
        idle_n      = idle_q;
        app_n       = 1'b0;
        acnt_n      = acnt_q;
        ready_n     = card_ready;
        clr_ur      = 1'b0;
        rd_new      = 1'b0;
        resp_long_n = 1'b0;
        payload     = 32'hFFFF_FFFF;
        r1          = r1_byte(idle_q, 1'b0);
        case (fr_idx_q)
            CmdGoIdle: begin
                idle_n  = 1'b1;
                acnt_n  = 8'd0;
                ready_n = 1'b0;
                clr_ur  = 1'b1;
                r1      = r1_byte(1'b1, 1'b0);
            end
            CmdSendIfCond: begin
                resp_long_n = 1'b1;
                payload     = {16'h0000, 4'h0, fr_arg_q[11:8], fr_arg_q[7:0]};
            end
            CmdAppCmd: app_n = 1'b1;
            CmdAppOpCond: begin
                if (!app_q) begin
                    r1 = r1_byte(idle_q, 1'b1);
                end else if (acnt_q < BusyCount) begin
                    acnt_n = acnt_q + 8'd1;
                    r1     = r1_byte(1'b1, 1'b0);
                end else begin
                    idle_n  = 1'b0;
                    ready_n = 1'b1;
                    r1      = r1_byte(1'b0, 1'b0);
                end
            end
            CmdReadOcr: begin
                resp_long_n = 1'b1;
                payload     = Ocr;
            end
            CmdReadSingle: begin
                if (idle_q) begin
                    r1 = r1_byte(1'b1, 1'b1);
                end else begin
                    rd_new = 1'b1;
                end
            end
            default: r1 = r1_byte(idle_q, 1'b1);
        endcase
        resp_new = {r1, payload};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fr_idx_d   = fr_idx_q;
        fr_arg_d   = fr_arg_q;
        tx_byte    = 8'hFF;
        exec       = 1'b0;
        req        = 1'b0;
        load_data  = 1'b0;
        resp_shift = 1'b0;
        if (cs_high) begin
            state_d = StHunt;
            cnt_d   = 10'd0;
        end else if (byte_done) begin
            // tx_byte chosen here is the byte for the slot that starts now.
            unique case (state_q)
                StHunt: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        state_d  = StCmd;
                        fr_idx_d = rx_byte[5:0];
                        cnt_d    = 10'd0;
                    end
                end
                StCmd: begin
                    if (cnt_q == 10'd4) begin
                        exec  = 1'b1;
                        cnt_d = 10'd0;
                        if (NCR_BYTES == 0) begin
                            state_d = StResp;
                            tx_byte = resp_new[39:32];
                        end else begin
                            state_d = StNcr;
                        end
                    end else begin
                        fr_arg_d = {fr_arg_q[23:0], rx_byte};
                        cnt_d    = cnt_q + 10'd1;
                    end
                end
                StNcr: begin
                    if (cnt_q == NcrLast) begin
                        state_d    = StResp;
                        tx_byte    = resp_q[39:32];
                        resp_shift = 1'b1;
                        cnt_d      = 10'd0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                StResp: begin
                    if (cnt_q == (resp_long_q ? 10'd4 : 10'd0)) begin
                        cnt_d = 10'd0;
                        if (!rd_q) begin
                            state_d = StHunt;
                        end else if (NAC_BYTES == 0) begin
                            state_d = StToken;
                            tx_byte = DataToken;
                            req     = 1'b1;
                        end else begin
                            state_d = StNac;
                        end
                    end else begin
                        tx_byte    = resp_q[39:32];
                        resp_shift = 1'b1;
                        cnt_d      = cnt_q + 10'd1;
                    end
                end
                StNac: begin
                    if (cnt_q == NacLast) begin
                        state_d = StToken;
                        tx_byte = DataToken;
                        req     = 1'b1;
                        cnt_d   = 10'd0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                StToken: begin
                    state_d   = StData;
                    cnt_d     = 10'd0;
                    load_data = 1'b1;
                    req       = 1'b1;
                end
                StData: begin
                    if (cnt_q == 10'd511) begin
                        state_d = StCrc;
                        cnt_d   = 10'd0;
                    end else begin
                        load_data = 1'b1;
                        cnt_d     = cnt_q + 10'd1;
                        // Loading byte 511 needs no further prefetch.
                        req       = (cnt_q != 10'd510);
                    end
                end
                StCrc: begin
                    if (cnt_q == 10'd1) begin
                        state_d = StHunt;
                        cnt_d   = 10'd0;
                    end else begin
                        cnt_d = 10'd1;
                    end
                end
                default: state_d = StHunt;
            endcase
            if (load_data) begin
                tx_byte = have_q ? data_q : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            cnt_q       <= 10'd0;
            fr_idx_q    <= 6'd0;
            fr_arg_q    <= 32'd0;
            resp_q      <= 40'hFF_FFFF_FFFF;
            resp_long_q <= 1'b0;
            rd_q        <= 1'b0;
            idle_q      <= 1'b1;
            app_q       <= 1'b0;
            acnt_q      <= 8'd0;
            data_q      <= 8'd0;
            have_q      <= 1'b0;
            pend_q      <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_index   <= 6'd0;
            cmd_arg     <= 32'd0;
            card_ready  <= 1'b0;
            blk_addr    <= 32'd0;
            byte_req    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fr_idx_q  <= fr_idx_d;
            fr_arg_q  <= fr_arg_d;
            cmd_valid <= exec;
            byte_req  <= req;
            if (resp_shift) begin
                resp_q <= {resp_q[31:0], 8'hFF};
            end
            if (exec) begin
                cmd_index   <= fr_idx_q;
                cmd_arg     <= fr_arg_q;
                idle_q      <= idle_n;
                app_q       <= app_n;
                acnt_q      <= acnt_n;
                card_ready  <= ready_n;
                rd_q        <= rd_new;
                resp_long_q <= resp_long_n;
                resp_q      <= (NCR_BYTES == 0) ? {resp_new[31:0], 8'hFF} : resp_new;
                if (rd_new) begin
                    blk_addr <= fr_arg_q;
                end
            end
            if (cs_high) begin
                have_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                if (load_data) begin
                    have_q <= 1'b0;
                    if (!have_q) begin
                        underrun <= 1'b1;
                    end
                end else if (byte_valid && pend_q) begin
                    data_q <= byte_in;
                    have_q <= 1'b1;
                    pend_q <= 1'b0;
                end
                if (req) begin
                    pend_q <= 1'b1;
                end
            end
            if (exec && clr_ur) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_card_responder.sv
// Self-checking bench for sd_card_responder: a host model drives SPI frames,
// expected miso bytes are queued per command and compared as they arrive.
module tb_sd_card_responder;

    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        rst, spi_clk, cs, mosi, miso;
    logic        cmd_valid, card_ready, byte_req, byte_valid, underrun;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg, blk_addr;
    logic [7:0]  byte_in;
    logic [7:0]  rx;

    int checks = 0, failures = 0;
    int cmd_cnt = 0, req_total = 0, req_base = 0, withhold = -1, src_idx, snap;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sd_card_responder #(
        .ACMD41_BUSY_COUNT (2),
        .NCR_BYTES         (1),
        .NAC_BYTES         (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .cmd_valid  (cmd_valid),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .card_ready (card_ready),
        .blk_addr   (blk_addr),
        .byte_req   (byte_req),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .underrun   (underrun)
    );

    always @(negedge clk) if (cmd_valid === 1'b1) cmd_cnt++;

    // Block source: answers each request one cycle later with index mod 256.
    initial begin
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        forever begin
            @(negedge clk);
            byte_valid = 1'b0;
            if (byte_req === 1'b1) begin
                src_idx = req_total - req_base;
                req_total++;
                if (src_idx != withhold) begin
                    byte_in    = 8'(src_idx);
                    byte_valid = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #(HALF);
            rxb[i] = miso;
            spi_clk = 1'b1;
            #(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic xfer_check(input logic [7:0] tx, input string tag);
        logic [7:0]  r;
        logic [31:0] e;
        xfer(tx, r);
        if (exp_q.size() > 0) e = {24'h0, exp_q.pop_front()};
        else e = 32'hDEAD;
        check(tag, {24'h0, r}, e);
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [7:0] crc);
        logic [47:0] f;
        f = {2'b01, idx, arg, crc};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(8'hFF);
            xfer_check(f[47-8*i -: 8], "frame");
        end
    endtask

    task automatic read(input int n, input string tag);
        repeat (n) xfer_check(8'hFF, tag);
    endtask

    task automatic push5(input logic [7:0] a, b, c, d, e);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        exp_q.push_back(d); exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_miso", miso, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_card_ready", card_ready, 0);
        check("rst_byte_req", byte_req, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Power-up clocks with cs high, then CMD0.
        repeat (10) xfer(8'hFF, rx);
        cs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_frame(6'd0, 32'h0, 8'h95);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        read(2, "cmd0");
        check("cmd0_valid_cnt", cmd_cnt, 1);
        check("cmd0_index", cmd_index, 0);

        send_frame(6'd8, 32'h0000_01AA, 8'h87);
        exp_q.push_back(8'hFF); push5(8'h01, 8'h00, 8'h00, 8'h01, 8'hAA);
        read(6, "cmd8");
        check("cmd8_index", cmd_index, 8);
        check("cmd8_arg", cmd_arg, 32'h1AA);

        // Read before initialisation: R1 05 and no token.
        send_frame(6'd17, 32'h0, 8'h01);
        exp_q.push_back(8'hFF); push5(8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        read(6, "cmd17_idle");
        check("cmd17_idle_no_req", req_total, 0);

        for (int i = 0; i < 3; i++) begin
            send_frame(6'd55, 32'h0, 8'h01);
            exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
            read(2, "cmd55");
            send_frame(6'd41, 32'h4000_0000, 8'h01);
            exp_q.push_back(8'hFF); exp_q.push_back((i < 2) ? 8'h01 : 8'h00);
            read(2, "acmd41");
            check("card_ready", card_ready, (i == 2) ? 1 : 0);
        end

        send_frame(6'd58, 32'h0, 8'h01);
        exp_q.push_back(8'hFF); push5(8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00);
        read(6, "cmd58");

        // Full block read.
        req_base = req_total;
        send_frame(6'd17, 32'h0000_0010, 8'h01);
        push5(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE);
        for (int k = 0; k < 512; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        read(520, "blk");
        check("blk_addr", blk_addr, 32'h10);
        check("blk_req_cnt", req_total - req_base, 512);
        check("blk_underrun", underrun, 0);

        // Read with byte 5 withheld, aborted mid data byte 100.
        req_base = req_total;
        withhold = 5;
        send_frame(6'd17, 32'h0000_0020, 8'h01);
        push5(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE);
        for (int k = 0; k < 100; k++) exp_q.push_back((k == 5) ? 8'h00 : 8'(k));
        read(105, "blk_ur");
        check("ur_set", underrun, 1);
        check("ur_blk_addr", blk_addr, 32'h20);
        mosi = 1'b1;
        repeat (3) begin
            #(HALF) spi_clk = 1'b1;
            #(HALF) spi_clk = 1'b0;
        end
        cs = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_miso", miso, 1);
        snap = req_total;
        repeat (2) xfer(8'hFF, rx);
        check("abort_no_req", req_total, snap);
        withhold = -1;
        cs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_frame(6'd0, 32'h0, 8'h95);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        read(2, "abort_cmd0");
        check("cmd0_clears_ur", underrun, 0);
        check("cmd0_not_ready", card_ready, 0);

        // Reset in the middle of a CMD8 frame.
        send_frame(6'd8, 32'h0000_01AA, 8'h87);
        exp_q.push_back(8'hFF); push5(8'h01, 8'h00, 8'h00, 8'h01, 8'hAA);
        read(6, "cmd8_again");
        xfer(8'h48, rx); xfer(8'h00, rx); xfer(8'h00, rx);
        rst = 1'b1;
        #2;
        check("mid_rst_miso", miso, 1);
        check("mid_rst_cmd_valid", cmd_valid, 0);
        check("mid_rst_cmd_index", cmd_index, 0);
        check("mid_rst_cmd_arg", cmd_arg, 0);
        check("mid_rst_card_ready", card_ready, 0);
        check("mid_rst_blk_addr", blk_addr, 0);
        check("mid_rst_byte_req", byte_req, 0);
        check("mid_rst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_frame(6'd0, 32'h0, 8'h95);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        read(2, "post_rst_cmd0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
